// File: rtl/fe_sniff_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fe_sniff_scheduler_if                                              |
// | Sniff FIFO write port: strobe, 18-bit entry and full back-pressure |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fe_sniff_scheduler_if;
  logic        fifo_wr;
  logic [17:0] fifo_din;
  logic        fifo_full;

  modport master (output fifo_wr, output fifo_din, input fifo_full);
  modport slave  (input fifo_wr, input fifo_din, output fifo_full);
endinterface
`default_nettype wire

// File: rtl/fe_sniff_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fe_sniff_scheduler                                                 |
// | Timestamps PHY DATA/STAT events, queues them and serialises them   |
// | into DATA/STAT/TIME FIFO entries. FE_SNIFF_STAT_EN enables STAT.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fe_sniff_scheduler #(
  parameter int pQDEPTH = 4,
  parameter int pTIME_W = 16
) (
  input  wire logic             fe_clk,
  input  wire logic             reset_n,
  input  wire logic             capture_en,
  input  wire logic             fe_rxvalid,
  input  wire logic [7:0]       fe_data,
  input  wire logic [4:0]       fe_status,
  input  wire logic             overflow_clr,
  fe_sniff_scheduler_if.master  fifo_if,
  output logic                  overflow,
  output logic [2:0]            q_level
);

  localparam int c_AW = $clog2(pQDEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [pTIME_W-1:0] c_DMAX = {pTIME_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_TIME_PRE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rxvalid;
  logic [7:0]          r_data;
  logic                w_data_ev, w_stat_ev, w_arrival;
  logic [7:0]          w_first_pay;
  logic [c_CW-1:0]     w_push_n, w_free;
  logic                w_accept, w_drop;
  logic                r_q_stat  [pQDEPTH];
  logic [7:0]          r_q_pay   [pQDEPTH];
  logic [pTIME_W-1:0]  r_q_delta [pQDEPTH];
  logic [c_AW-1:0]     r_rd, r_wr;
  logic [c_CW-1:0]     r_count;
  logic [pTIME_W-1:0]  r_delta;
  logic                w_h_stat;
  logic [7:0]          w_h_pay;
  logic [pTIME_W-1:0]  w_h_delta;
  logic                w_last;
  logic                w_wr, w_pop, w_clr_head, w_marker;
  logic [17:0]         w_din;
  logic                r_fifo_wr;
  logic [17:0]         r_fifo_din;
  logic                r_overflow;

  function automatic logic [17:0] f_entry(input logic st, input logic [7:0] pay,
                                          input logic [2:0] dly);
    f_entry = st ? {2'b01, 8'h00, pay[4:0], dly} : {2'b00, pay, 5'b00000, dly};
  endfunction

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxvalid <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_rxvalid <= fe_rxvalid;
      r_data    <= fe_data;
    end
  end

`ifdef FE_SNIFF_STAT_EN
  logic [4:0]      r_status, r_status_prev;
  logic [c_AW-1:0] w_wr1;

  // History keeps tracking while capture is off so enabling never fakes a change.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_status      <= 5'b00000;
      r_status_prev <= 5'b00000;
    end else begin
      r_status      <= fe_status;
      r_status_prev <= r_status;
    end
  end

  assign w_stat_ev   = (r_status != r_status_prev);
  assign w_first_pay = w_data_ev ? r_data : {3'b000, r_status};
  assign w_wr1       = r_wr + c_AW'(1);
`else
  wire w_unused_status = ^fe_status;
  assign w_stat_ev   = 1'b0;
  assign w_first_pay = r_data;
`endif

  assign w_data_ev = r_rxvalid;
  assign w_arrival = capture_en && (w_data_ev || w_stat_ev);
  assign w_push_n  = c_CW'(w_data_ev) + c_CW'(w_stat_ev);
  // Space is judged before this cycle's pop; a pair is accepted or dropped as a unit.
  assign w_free    = c_CW'(pQDEPTH) - r_count;
  assign w_accept  = w_arrival && (w_push_n <= w_free);
  assign w_drop    = w_arrival && (w_push_n > w_free);

  assign w_h_stat  = r_q_stat[r_rd];
  assign w_h_pay   = r_q_pay[r_rd];
  assign w_h_delta = r_q_delta[r_rd];
  assign w_last    = (r_count == c_CW'(1)) && !w_accept;

  always_ff @(posedge fe_clk) begin
    if (w_accept) begin
      r_q_stat[r_wr]  <= ~w_data_ev;
      r_q_pay[r_wr]   <= w_first_pay;
      r_q_delta[r_wr] <= r_delta;
`ifdef FE_SNIFF_STAT_EN
      if (w_data_ev && w_stat_ev) begin
        r_q_stat[w_wr1]  <= 1'b1;
        r_q_pay[w_wr1]   <= {3'b000, r_status};
        r_q_delta[w_wr1] <= '0;
      end
`endif
    end
    if (w_clr_head) r_q_delta[r_rd] <= '0;
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (!capture_en) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)    r_rd <= r_rd + c_AW'(1);
      if (w_accept) r_wr <= r_wr + c_AW'(w_push_n);
      r_count <= r_count + (w_accept ? w_push_n : '0) - c_CW'(w_pop);
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n)                r_delta <= '0;
    else if (!capture_en)        r_delta <= '0;
    else if (w_arrival)          r_delta <= pTIME_W'(1);
    else if (w_marker)           r_delta <= '0;
    else if (r_delta != c_DMAX)  r_delta <= r_delta + pTIME_W'(1);
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_din       = 18'h00000;
    w_pop       = 1'b0;
    w_clr_head  = 1'b0;
    w_marker    = 1'b0;
    if (!capture_en) begin
      w_state_nxt = S_IDLE;
    end else if (!fifo_if.fifo_full) begin
      case (r_state)
        S_TIME_PRE: begin
          w_wr        = 1'b1;
          w_din       = f_entry(w_h_stat, w_h_pay, 3'd0);
          w_pop       = 1'b1;
          w_state_nxt = w_last ? S_IDLE : S_ISSUE;
        end
        default: begin
          // IDLE issues directly so the no-TIME path keeps its 3-edge latency.
          if (r_count != '0) begin
            w_wr = 1'b1;
            if (w_h_delta > pTIME_W'(7)) begin
              w_din       = {2'b10, 16'(w_h_delta)};
              w_clr_head  = 1'b1;
              w_state_nxt = S_TIME_PRE;
            end else begin
              w_din       = f_entry(w_h_stat, w_h_pay, w_h_delta[2:0]);
              w_pop       = 1'b1;
              w_state_nxt = w_last ? S_IDLE : S_ISSUE;
            end
          end else begin
            w_state_nxt = S_IDLE;
            if (r_delta == c_DMAX && !w_arrival) begin
              w_wr     = 1'b1;
              w_din    = {2'b10, 16'hFFFF};
              w_marker = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_wr  <= 1'b0;
      r_fifo_din <= 18'h00000;
      r_overflow <= 1'b0;
    end else begin
      r_fifo_wr  <= w_wr;
      r_fifo_din <= w_din;
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  assign fifo_if.fifo_wr  = r_fifo_wr;
  assign fifo_if.fifo_din = r_fifo_din;
  assign overflow         = r_overflow;
  assign q_level          = 3'(r_count);

endmodule
`default_nettype wire
